spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

Receive-side SPI slave that sits directly downstream of the team's SPI master. It samples `sclk`, `cs` and `mosi` in the system `clk` domain, deserialises one LSB-first frame per chip-select assertion and presents the word on `dout` with a one-cycle `done` strobe. It is the capture stage for the master/slave loopback, so its frame format matches the master exactly:
- one lead-in `sclk` period after `cs` falls;
- 12 data bits, LSB first, `mosi` updated on `sclk` rising edges;
- `cs` raised after the last bit.

## Interface
Parameters:
- `DATA_W`, 12, frame payload width in bits.
- `LEAD_EDGES`, 1, `sclk` falling edges after `cs` assertion that carry no data and are skipped.
- `SYNC_STAGES`, 2, flip-flop stages in each input synchroniser (minimum 2).

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sclk`  in  1  serial clock from the master, asynchronous to `clk`.
- `cs`  in  1  chip select, active low.
- `mosi`  in  1  serial data from the master.
- `dout`  out  `DATA_W`  last good received word; held until the next good frame.
- `done`  out  1  one-`clk` pulse when `dout` updates.
- `err`  out  1  one-`clk` pulse on a malformed frame. Present only with `SPI_SLAVE_FRAME_ERR_EN`.

## Operation
- **Synchronisers.** `sclk`, `cs` and `mosi` each pass through `SYNC_STAGES` flops.
  - `mosi` uses the same depth as `sclk`, so their alignment is preserved.
  - Edge detect compares the last synchroniser stage with one further registered copy.
- **Reset values.**
  - `dout`=0, `done`=0, `err`=0, state=IDLE, bit counter=0, shift register=0.
  - `sclk` synchroniser chain resets to 0.
  - `cs` synchroniser chain resets to 0, i.e. "asserted". A frame already in progress at reset release therefore produces no `cs` falling edge and is ignored until `cs` goes high and falls again.
- **FSM states and transitions.**
  - IDLE: on a synchronised `cs` falling edge, go to LEAD; lead counter=0, bit counter=0.
  - LEAD: each `sclk` falling edge increments the lead counter. At `LEAD_EDGES`, go to SHIFT. If `LEAD_EDGES`=0, go directly from IDLE to SHIFT.
  - SHIFT: each `sclk` falling edge shifts synchronised `mosi` into the MSB of the shift register, shifting right. After `DATA_W` bits, bit 0 of the frame is at `dout[0]`.
    - The bit counter increments and saturates at `DATA_W`+1.
  - Any state except IDLE, on a `cs` rising edge: go to IDLE.
    - If in SHIFT with bit count == `DATA_W`: load `dout` from the shift register and pulse `done`.
    - Otherwise the frame is malformed: `dout` is unchanged and `done` stays low.
- **Boundary conditions.**
  - `sclk` edges while in IDLE are ignored.
  - A `cs` rising edge in IDLE is ignored.
  - A `sclk` falling edge in the same `clk` cycle as a `cs` rising edge is ignored; the `cs` edge wins.
  - `rst` asserted mid-frame: state returns to IDLE next cycle with all reset values, and no `done` is issued.
- **Frame spacing.** Back-to-back frames need only `cs` to be high for at least one synchronised `clk` cycle between them.

## Timing
- `done` rises exactly `SYNC_STAGES`+1 `clk` cycles after `cs` rises at the pin. `dout` is valid in the same cycle and stays stable afterwards.
- `done` and `err` are each high for exactly one cycle per frame and are never high together.
- `sclk` high and low phases must each last at least `SYNC_STAGES`+2 `clk` cycles. The master's 11-cycle phases satisfy this.
- `mosi` must be stable for at least `SYNC_STAGES`+1 `clk` cycles before each `sclk` falling edge. This is guaranteed when the master changes `mosi` only on rising edges.

## Configuration
- Macro: `SPI_SLAVE_FRAME_ERR_EN`.
- **Defined:**
  - The `err` port exists.
  - `err` pulses one cycle, at the same point `done` would have pulsed, when `cs` rises in LEAD, or in SHIFT with bit count ≠ `DATA_W` (short, or long/saturated).
- **Undefined:**
  - No `err` port and no error logic.
  - Malformed frames are dropped silently; `done` behaviour is identical to the defined case.

## Test plan
- **Single frame:** master sends `din`=12'hA5C → `dout`=12'hA5C, exactly one `done` pulse, `SYNC_STAGES`+1 cycles after `cs` rises.
- **Back-to-back frames:** 12'h001 then 12'h800 → two `done` pulses, `dout`=12'h001 then 12'h800. No bit leaks between frames.
- **Reset mid-frame:** pulse `rst` after 5 data bits of 12'hFFF, then a fresh frame 12'h3C3 → no `done` for the first frame, one `done` with `dout`=12'h3C3.
- **Short frame:** `cs` raised after 6 data bits, preceded by a good 12'h123 → `dout` stays 12'h123, no `done`. With the macro, one `err` pulse.
- **Long frame:** 14 data edges before `cs` rises → no `done`, `dout` unchanged. With the macro, one `err` pulse.
- **`cs` glitch:** `cs` low for 30 `clk` cycles with `sclk` idle → no `done`. With the macro, one `err` pulse (`cs` rises while still in LEAD).

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI receive slave: LSB-first deserialiser, one word per chip-select frame.
// Define SPI_SLAVE_FRAME_ERR_EN to add the err port that flags malformed frames.
module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int LEAD_EDGES  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic              err
`endif
);
    localparam int LW = (LEAD_EDGES < 2) ? 1 : $clog2(LEAD_EDGES + 1);
    localparam int BW = $clog2(DATA_W + 2);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic [LW-1:0]          r_lead_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic [DATA_W-1:0]      r_dout;
    logic                   r_done;

    logic w_sclk_fall;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_mosi;
    logic w_clr;
    logic w_lead_inc;
    logic w_shift;
    logic w_load;

    // cs chain resets to "asserted" so a frame in flight at reset release yields no falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_fall = r_sclk_d & ~r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_fall   = r_cs_d & ~r_cs_sync[SYNC_STAGES-1];
    assign w_cs_rise   = ~r_cs_d & r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A cs rising edge takes priority over a coincident sclk falling edge
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_lead_inc  = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_clr       = 1'b1;
                    w_state_nxt = (LEAD_EDGES == 0) ? SHIFT : LEAD;
                end
            end
            LEAD: begin
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
                end else if (w_sclk_fall) begin
                    w_lead_inc = 1'b1;
                    if (r_lead_cnt == LW'(LEAD_EDGES - 1)) begin
                        w_state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
                    w_load      = (r_bit_cnt == BW'(DATA_W));
                end else if (w_sclk_fall) begin
                    w_shift = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lead_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_dout     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_load;
            if (w_clr) begin
                r_lead_cnt <= '0;
                r_bit_cnt  <= '0;
            end
            if (w_lead_inc) begin
                r_lead_cnt <= r_lead_cnt + LW'(1);
            end
            if (w_shift) begin
                r_shift <= {w_mosi, r_shift[DATA_W-1:1]};
                if (r_bit_cnt != BW'(DATA_W + 1)) begin
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                end
            end
            if (w_load) begin
                r_dout <= r_shift;
            end
        end
    end

    assign dout = r_dout;
    assign done = r_done;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic w_bad;
    logic r_err;

    assign w_bad = w_cs_rise && (r_state != IDLE) && !w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_bad;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomised scoreboard bench for spi_slave_rx: stimulus pushes expected frame
// outcomes, an independent monitor pops them whenever done/err fires.
module tb_spi_slave_rx;
    localparam int DATA_W = 12;
    localparam int LEAD   = 1;
    localparam int SYNC   = 2;
    localparam int HALF   = 11;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        bit          is_err;
        logic [11:0] data;
        int          t;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic [DATA_W-1:0] dout;
    logic              done;
    logic              err_w;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    exp_t        q[$];
    exp_t        m_e;
    logic [11:0] last_good;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic err;
    assign err_w = err;
`else
    assign err_w = 1'b0;
`endif

    spi_slave_rx #(
        .DATA_W     (DATA_W),
        .LEAD_EDGES (LEAD),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sclk(sclk),
        .cs  (cs),
        .mosi(mosi),
        .dout(dout),
`ifdef SPI_SLAVE_FRAME_ERR_EN
        .err (err),
`endif
        .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame outcome model: a frame is good only when exactly LEAD+DATA_W
    // sclk falling edges occur while cs is low (a fall coincident with cs rising is lost).
    task automatic send_frame(input logic [15:0] d, input int nbits, input int nlead,
                              input bit simul, input int pre);
        int   nfall;
        exp_t e;
        nfall = 0;
        cs = 1'b0;
        tick(pre);
        for (int i = 0; i < nlead; i++) begin
            sclk = 1'b1; tick(HALF);
            sclk = 1'b0; nfall++; tick(HALF);
        end
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1; mosi = d[i]; tick(HALF);
            sclk = 1'b0; nfall++; tick(HALF);
        end
        if (simul) begin
            sclk = 1'b1; tick(HALF);
            sclk = 1'b0;
        end
        cs       = 1'b1;
        e.t      = cyc;
        e.is_err = (nfall != LEAD + DATA_W);
        e.data   = d[11:0];
        if (!e.is_err) begin
            last_good = d[11:0];
            q.push_back(e);
        end else if (ERR_EN) begin
            q.push_back(e);
        end
        tick(HALF);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1 || err_w === 1'b1) begin
            chk("done_err_exclusive", {31'b0, done & err_w}, 32'd0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event done=%0b err=%0b dout=%0h cycle=%0d",
                         done, err_w, dout, cyc);
            end else begin
                m_e = q.pop_front();
                chk("event_kind_err", {31'b0, err_w}, {31'b0, m_e.is_err});
                if (!m_e.is_err) chk("dout_on_done", {20'b0, dout}, {20'b0, m_e.data});
                chk("event_latency", cyc - m_e.t, SYNC + 1);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        int          nb;
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; last_good = '0;
        tick(4);
        chk("reset_dout", {20'b0, dout}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_err",  {31'b0, err_w}, 32'd0);
        rst = 1'b0;
        tick(6);
        repeat (3) begin
            sclk = 1'b1; tick(HALF);
            sclk = 1'b0; tick(HALF);
        end
        send_frame(16'h0A5C, 12, 1, 1'b0, HALF);
        chk("single_frame_dout", {20'b0, dout}, 32'h0A5C);
        send_frame(16'h0001, 12, 1, 1'b0, HALF);
        send_frame(16'h0800, 12, 1, 1'b0, HALF);
        chk("b2b_dout", {20'b0, dout}, 32'h0800);

        cs = 1'b0; tick(HALF);
        sclk = 1'b1; tick(HALF); sclk = 1'b0; tick(HALF);
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b1; mosi = 1'b1; tick(HALF);
            sclk = 1'b0; tick(HALF);
        end
        rst = 1'b1; tick(2); rst = 1'b0;
        last_good = '0;
        tick(3);
        chk("midrst_dout", {20'b0, dout}, 32'd0);
        cs = 1'b1; tick(2 * HALF);
        send_frame(16'h03C3, 12, 1, 1'b0, HALF);
        chk("after_rst_dout", {20'b0, dout}, 32'h03C3);

        send_frame(16'h0123, 12, 1, 1'b0, HALF);
        send_frame(16'h0FFF, 6, 1, 1'b0, HALF);
        chk("short_hold", {20'b0, dout}, 32'h0123);
        send_frame(16'hBEEF, 14, 1, 1'b0, HALF);
        chk("long_hold", {20'b0, dout}, 32'h0123);
        send_frame(16'h0000, 0, 0, 1'b0, 30);
        chk("glitch_hold", {20'b0, dout}, 32'h0123);
        send_frame(16'h05A7, 12, 1, 1'b1, HALF);
        chk("coincident_edge", {20'b0, dout}, 32'h05A7);

        for (int k = 0; k < 20; k++) begin
            rd = 16'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 12;
            send_frame(rd, nb, 1, 1'($urandom_range(0, 1)), HALF);
            chk("random_hold", {20'b0, dout}, {20'b0, last_good});
        end

        tick(40);
        chk("queue_drained", q.size(), 32'd0);
        chk("final_dout", {20'b0, dout}, {20'b0, last_good});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
